tc_cascade_counter: RTL and testbench

Cascadable counter stage placed directly downstream of the 4-bit terminal-count counter. It advances once per upstream carry (the upstream `cnt_tc` qualified by the upstream enable) and produces its own terminal count and carry-out for further chaining. It supports a synchronous load, equivalent to a deposit, and a 2-entry snapshot buffer with a valid/ready readout handshake. Together with the upstream stage it forms a multi-digit counter that the bench can preset and sample.

---
 rtl/tc_cascade_pkg.sv | 14 +
 rtl/snap_fifo2.sv | 68 ++++++
 rtl/tc_cascade_counter.sv | 68 ++++++
 tb/tb_tc_cascade_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tc_cascade_pkg.sv
// Shared types and helpers for the cascadable terminal-count counter stage.
package tc_cascade_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } snap_st_e;

  function automatic int unsigned clamp_ld(input int unsigned value, input int unsigned max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/snap_fifo2.sv
// Two-entry snapshot FIFO with valid/ready readout and a sticky drop flag.
module snap_fifo2
  import tc_cascade_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             drop
);

  snap_st_e         state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign valid = (state != EMPTY);
  assign dout  = head;
  assign pop   = valid & ready;

  always_ff @(posedge ck) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      drop  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= din;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= din;
          end else if (push) begin
            tail  <= din;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // A pop frees the head slot in the same cycle, so a push alongside it is never dropped.
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= din;
            end else begin
              state <= ONE;
            end
          end else if (push) begin
            drop <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/tc_cascade_counter.sv
// Cascadable counter stage: advances on upstream carry, with load, terminal count,
// carry-out, sticky overflow and a two-entry snapshot buffer.
module tc_cascade_counter
  import tc_cascade_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15,
  parameter int unsigned WRAP  = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic             ci,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             co,
  output logic             ovf,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_drop
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic             WRAP_B = (WRAP != 0);

  logic [WIDTH-1:0] ld_clamped;
  logic             roll;

  assign ld_clamped = WIDTH'(clamp_ld(32'(ld_val), MAX));
  assign tc         = (cnt == MAX_V);
  assign roll       = WRAP_B | start;
  assign co         = ci & tc & ~ld & roll;

  always_ff @(posedge ck) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (ld) begin
      cnt <= ld_clamped;
      ovf <= 1'b0;
    end else if (ci) begin
      if (!tc) begin
        cnt <= cnt + WIDTH'(1);
      end else if (roll) begin
        cnt <= '0;
        ovf <= 1'b1;
      end
    end
  end

  snap_fifo2 #(
    .WIDTH(WIDTH)
  ) u_snap (
    .ck   (ck),
    .rst  (rst),
    .push (snap_req),
    .din  (cnt),
    .ready(snap_ready),
    .valid(snap_valid),
    .dout (snap_data),
    .drop (snap_drop)
  );

endmodule

// File: tb/tb_tc_cascade_counter.sv
// Directed bench for tc_cascade_counter: wrap, saturate, load, cascade and snapshot buffer.
module tb_tc_cascade_counter;

  logic ck;
  int n_cmp;
  int n_err;

  // u_a: MAX=15, WRAP=1
  logic a_rst, a_start, a_ci, a_ld, a_snap_req, a_snap_ready;
  logic [3:0] a_ld_val, a_cnt, a_snap_data;
  logic a_tc, a_co, a_ovf, a_snap_valid, a_snap_drop;

  // u_s: MAX=9, WRAP=0
  logic s_rst, s_start, s_ci, s_ld;
  logic [3:0] s_ld_val, s_cnt, s_snap_data;
  logic s_tc, s_co, s_ovf, s_snap_valid, s_snap_drop;

  // cascade pair
  logic c_rst, c_ci, c_ld;
  logic [3:0] lo_val, hi_val, lo_cnt, hi_cnt, lo_sd, hi_sd;
  logic lo_tc, lo_co, lo_ovf, lo_sv, lo_drop;
  logic hi_tc, hi_co, hi_ovf, hi_sv, hi_drop;

  tc_cascade_counter #(.WIDTH(4), .MAX(15), .WRAP(1)) u_a (
    .ck(ck), .rst(a_rst), .start(a_start), .ci(a_ci), .ld(a_ld), .ld_val(a_ld_val),
    .cnt(a_cnt), .tc(a_tc), .co(a_co), .ovf(a_ovf),
    .snap_req(a_snap_req), .snap_valid(a_snap_valid), .snap_ready(a_snap_ready),
    .snap_data(a_snap_data), .snap_drop(a_snap_drop)
  );

  tc_cascade_counter #(.WIDTH(4), .MAX(9), .WRAP(0)) u_s (
    .ck(ck), .rst(s_rst), .start(s_start), .ci(s_ci), .ld(s_ld), .ld_val(s_ld_val),
    .cnt(s_cnt), .tc(s_tc), .co(s_co), .ovf(s_ovf),
    .snap_req(1'b0), .snap_valid(s_snap_valid), .snap_ready(1'b0),
    .snap_data(s_snap_data), .snap_drop(s_snap_drop)
  );

  tc_cascade_counter #(.WIDTH(4), .MAX(15), .WRAP(1)) u_lo (
    .ck(ck), .rst(c_rst), .start(1'b0), .ci(c_ci), .ld(c_ld), .ld_val(lo_val),
    .cnt(lo_cnt), .tc(lo_tc), .co(lo_co), .ovf(lo_ovf),
    .snap_req(1'b0), .snap_valid(lo_sv), .snap_ready(1'b0),
    .snap_data(lo_sd), .snap_drop(lo_drop)
  );

  tc_cascade_counter #(.WIDTH(4), .MAX(15), .WRAP(1)) u_hi (
    .ck(ck), .rst(c_rst), .start(1'b0), .ci(lo_co), .ld(c_ld), .ld_val(hi_val),
    .cnt(hi_cnt), .tc(hi_tc), .co(hi_co), .ovf(hi_ovf),
    .snap_req(1'b0), .snap_valid(hi_sv), .snap_ready(1'b0),
    .snap_data(hi_sd), .snap_drop(hi_drop)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    a_rst = 1; a_start = 0; a_ci = 0; a_ld = 0; a_ld_val = '0; a_snap_req = 0; a_snap_ready = 0;
    s_rst = 1; s_start = 0; s_ci = 0; s_ld = 0; s_ld_val = '0;
    c_rst = 1; c_ci = 0; c_ld = 0; lo_val = '0; hi_val = '0;
    tick();
    a_rst = 0; s_rst = 0; c_rst = 0;

    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_valid", 32'(a_snap_valid), 0);
    chk("rst_data", 32'(a_snap_data), 0);
    chk("rst_drop", 32'(a_snap_drop), 0);

    // advance and wrap, MAX=15
    for (int i = 0; i < 16; i++) begin
      a_ci = 1;
      #1;
      chk("adv_cnt", 32'(a_cnt), 32'(i));
      chk("adv_tc", 32'(a_tc), (i == 15) ? 1 : 0);
      chk("adv_co", 32'(a_co), (i == 15) ? 1 : 0);
      tick();
    end
    a_ci = 0;
    chk("wrap_cnt", 32'(a_cnt), 0);
    chk("wrap_ovf", 32'(a_ovf), 1);

    // saturate at 9, then forced roll with start
    s_ci = 1;
    repeat (12) tick();
    chk("sat_cnt", 32'(s_cnt), 9);
    chk("sat_tc", 32'(s_tc), 1);
    chk("sat_co", 32'(s_co), 0);
    chk("sat_ovf", 32'(s_ovf), 0);
    s_start = 1;
    #1;
    chk("start_co", 32'(s_co), 1);
    tick();
    s_ci = 0; s_start = 0;
    chk("start_cnt", 32'(s_cnt), 0);
    chk("start_ovf", 32'(s_ovf), 1);

    // clamp load on MAX=9
    s_ld = 1; s_ld_val = 4'd13;
    tick();
    s_ld = 0;
    chk("clamp_cnt", 32'(s_cnt), 9);
    chk("clamp_tc", 32'(s_tc), 1);
    chk("clamp_ovf", 32'(s_ovf), 0);

    // load priority over advance
    a_ld = 1; a_ld_val = 4'd3;
    tick();
    chk("ld3_cnt", 32'(a_cnt), 3);
    a_ci = 1; a_ld_val = 4'd10;
    tick();
    a_ci = 0;
    chk("ldpri_cnt", 32'(a_cnt), 10);
    chk("ldpri_ovf", 32'(a_ovf), 0);
    a_ld_val = 4'd15;
    tick();
    a_ci = 1; a_ld_val = 4'd4;
    #1;
    chk("ldpri_tc", 32'(a_tc), 1);
    chk("ldpri_co", 32'(a_co), 0);
    tick();
    a_ci = 0; a_ld = 0;
    chk("ldpri_cnt4", 32'(a_cnt), 4);

    // cascade: preset 10 / 15, six carries
    c_ld = 1; lo_val = 4'd10; hi_val = 4'd15;
    tick();
    c_ld = 0;
    chk("cas_lo_pre", 32'(lo_cnt), 10);
    chk("cas_hi_pre", 32'(hi_cnt), 15);
    c_ci = 1;
    repeat (5) tick();
    chk("cas_lo5", 32'(lo_cnt), 15);
    chk("cas_hi5", 32'(hi_cnt), 15);
    chk("cas_lo_co", 32'(lo_co), 1);
    chk("cas_hi_co", 32'(hi_co), 1);
    tick();
    c_ci = 0;
    chk("cas_lo6", 32'(lo_cnt), 0);
    chk("cas_hi6", 32'(hi_cnt), 0);
    chk("cas_hi_ovf", 32'(hi_ovf), 1);

    // snapshot: captures at 2,3,4 with consumer stalled
    a_rst = 1;
    tick();
    a_rst = 0;
    a_ci = 1;
    repeat (2) tick();
    chk("snp_cnt2", 32'(a_cnt), 2);
    a_snap_req = 1;
    tick();
    chk("snp_v1", 32'(a_snap_valid), 1);
    chk("snp_d1", 32'(a_snap_data), 2);
    tick();
    chk("snp_d2", 32'(a_snap_data), 2);
    chk("snp_drop0", 32'(a_snap_drop), 0);
    tick();
    a_ci = 0; a_snap_req = 0;
    chk("snp_d3", 32'(a_snap_data), 2);
    chk("snp_drop1", 32'(a_snap_drop), 1);
    chk("snp_cnt5", 32'(a_cnt), 5);
    a_snap_ready = 1;
    tick();
    chk("pop1_v", 32'(a_snap_valid), 1);
    chk("pop1_d", 32'(a_snap_data), 3);
    tick();
    a_snap_ready = 0;
    chk("pop2_v", 32'(a_snap_valid), 0);

    // full push+pop, then reset
    a_rst = 1;
    tick();
    a_rst = 0;
    a_ld = 1; a_ld_val = 4'd5;
    tick();
    a_ld = 0;
    a_ci = 1; a_snap_req = 1;
    repeat (2) tick();
    a_ci = 0;
    chk("pp_pre_d", 32'(a_snap_data), 5);
    chk("pp_pre_cnt", 32'(a_cnt), 7);
    a_snap_ready = 1;
    tick();
    a_snap_req = 0;
    chk("pp_d", 32'(a_snap_data), 6);
    chk("pp_v", 32'(a_snap_valid), 1);
    chk("pp_drop", 32'(a_snap_drop), 0);
    tick();
    a_snap_ready = 0;
    chk("pp_tail", 32'(a_snap_data), 7);
    a_rst = 1; a_ci = 1; a_snap_req = 1; a_ld = 1;
    tick();
    a_rst = 0; a_ci = 0; a_snap_req = 0; a_ld = 0;
    chk("rst2_v", 32'(a_snap_valid), 0);
    chk("rst2_cnt", 32'(a_cnt), 0);
    chk("rst2_drop", 32'(a_snap_drop), 0);
    chk("rst2_data", 32'(a_snap_data), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
